// File: rtl/barrel_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_share_arbiter
// Description : Shares one external combinational barrel shifter among up to
//               four valid/ready requesters; returns result plus owner index.
//               Optional macro BARREL_ARB_RR_EN selects round-robin priority
//               (fixed lowest-index priority when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_share_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int AW   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*W-1:0]  req_a,
   input  logic [NREQ*AW-1:0] req_amt,
   output logic [W-1:0]       sh_a,
   output logic [AW-1:0]      sh_amt,
   input  logic [W-1:0]       sh_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [W-1:0]       out_y,
   output logic [1:0]         out_id,
   output logic               busy
);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_shift = 2'd1;
   localparam logic [1:0] c_resp  = 2'd2;

   logic [1:0]      r_state;
   logic [W-1:0]    r_a;
   logic [AW-1:0]   r_amt;
   logic [1:0]      r_win;
   logic [W-1:0]    r_y;
   logic [1:0]      r_id;

   logic [1:0]      w_start;
   logic            w_found;
   logic [1:0]      w_winner;
   logic [NREQ-1:0] w_grant;
   logic [W-1:0]    w_sel_a;
   logic [AW-1:0]   w_sel_amt;

`ifdef BARREL_ARB_RR_EN
   logic [1:0] r_ptr;

   // Search begins one past the last winner, wrapping at NREQ.
   always_comb begin
      w_start = (int'(r_ptr) == NREQ-1) ? 2'd0 : r_ptr + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= 2'(NREQ-1);
      end else if (r_state == c_idle && w_found) begin
         r_ptr <= w_winner;
      end
   end
`else
   assign w_start = 2'd0;
`endif

   always_comb begin
      int idx;
      w_found   = 1'b0;
      w_winner  = 2'd0;
      w_grant   = '0;
      w_sel_a   = '0;
      w_sel_amt = '0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(w_start) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         for (int j = 0; j < NREQ; j++) begin
            if (!w_found && j == idx && req_valid[j]) begin
               w_found    = 1'b1;
               w_winner   = 2'(j);
               w_grant[j] = 1'b1;
               w_sel_a    = req_a[j*W +: W];
               w_sel_amt  = req_amt[j*AW +: AW];
            end
         end
      end
   end

   assign req_ready = (r_state == c_idle) ? w_grant : '0;
   assign sh_a      = r_a;
   assign sh_amt    = r_amt;
   assign out_valid = (r_state == c_resp);
   assign out_y     = r_y;
   assign out_id    = r_id;
   assign busy      = (r_state != c_idle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_a     <= '0;
         r_amt   <= '0;
         r_win   <= 2'd0;
         r_y     <= '0;
         r_id    <= 2'd0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_found) begin
                  r_a     <= w_sel_a;
                  r_amt   <= w_sel_amt;
                  r_win   <= w_winner;
                  r_state <= c_shift;
               end
            end
            c_shift: begin
               r_y     <= sh_y;
               r_id    <= r_win;
               r_state <= c_resp;
            end
            c_resp: begin
               if (out_ready) r_state <= c_idle;
            end
            default: r_state <= c_idle;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_barrel_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_share_arbiter
// Description : Directed scoreboard bench for barrel_share_arbiter with a
//               rotate-right shifter stub; honours BARREL_ARB_RR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [11:0] req_amt;
   logic [7:0]  sh_a;
   logic [2:0]  sh_amt;
   logic [7:0]  sh_y;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_y;
   logic [1:0]  out_id;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [9:0] sb[$];

   always #5 clk = ~clk;

   function automatic logic [7:0] rotr(input logic [7:0] v, input logic [2:0] s);
      logic [15:0] d;
      d = {v, v} >> s;
      return d[7:0];
   endfunction

   assign sh_y = rotr(sh_a, sh_amt);

   barrel_share_arbiter #(.NREQ(4), .W(8), .AW(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_amt(req_amt),
      .sh_a(sh_a), .sh_amt(sh_amt), .sh_y(sh_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_y(out_y), .out_id(out_id), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a response, then compare it with the oldest expectation.
   task automatic collect(input string tag);
      int n;
      logic [9:0] e;
      n = 0;
      while (out_valid !== 1'b1 && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (out_valid === 1'b1) begin
         chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_id"}, 32'(out_id), 32'(e[9:8]));
            chk({tag, "_y"},  32'(out_y),  32'(e[7:0]));
         end
      end
   endtask

   task automatic run_op(input string tag, input int id, input logic [7:0] a,
                         input logic [2:0] amt, input logic [7:0] exp_y);
      logic [3:0] onehot;
      onehot = 4'b0001 << id;
      req_a[id*8 +: 8]  = a;
      req_amt[id*3 +: 3] = amt;
      req_valid = onehot;
      #1;
      chk({tag, "_grant"}, 32'(req_ready), 32'(onehot));
      sb.push_back({2'(id), exp_y});
      @(posedge clk); #1;
      req_valid = 4'b0000;
      chk({tag, "_shift_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_shift_busy"},  32'(busy), 32'd1);
      chk({tag, "_sh_a"},        32'(sh_a), 32'(a));
      chk({tag, "_sh_amt"},      32'(sh_amt), 32'(amt));
      chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      collect(tag);
      @(posedge clk); #1;
      chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_done_busy"},  32'(busy), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         assert ($onehot0(req_ready) && !(busy && |req_ready)) else begin
            errors++;
            $error("FAIL grant_onehot observed=%b busy=%b expected onehot0 and idle-only", req_ready, busy);
         end
      end
   end

   initial begin
      logic [7:0] exp_y[4];
      int         order[5];
      rst       = 1'b1;
      req_valid = 4'b0000;
      req_a     = '0;
      req_amt   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready",  32'(req_ready), 32'd0);
      chk("rst_sh_a",   32'(sh_a), 32'd0);
      chk("rst_sh_amt", 32'(sh_amt), 32'd0);
      chk("rst_valid",  32'(out_valid), 32'd0);
      chk("rst_out_y",  32'(out_y), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_busy",   32'(busy), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("r0_amt1", 0, 8'hCC, 3'd1, 8'h66);
      run_op("r0_amt0", 0, 8'hCC, 3'd0, 8'hCC);
      run_op("r0_amt7", 0, 8'hCC, 3'd7, 8'h99);
      run_op("r2_amt2", 2, 8'hCC, 3'd2, 8'h33);

      // Backpressure: requester 1 served, requester 3 waits behind a stalled response.
      req_a[15:8]  = 8'h0F;
      req_amt[5:3] = 3'd4;
      req_valid    = 4'b0010;
      #1;
      chk("bp_grant", 32'(req_ready), 32'b0010);
      sb.push_back({2'd1, 8'hF0});
      @(posedge clk); #1;
      req_a[31:24]  = 8'h81;
      req_amt[11:9] = 3'd1;
      req_valid     = 4'b1000;
      out_ready     = 1'b0;
      chk("bp_shift_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("bp_valid_rise", 32'(out_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_y",     32'(out_y), 32'hF0);
         chk("bp_hold_id",    32'(out_id), 32'd1);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp_hs_no_grant", 32'(req_ready), 32'd0);
      collect("bp_r1");
      sb.push_back({2'd3, 8'hC0});
      @(posedge clk); #1;
      chk("bp_next_grant", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      collect("bp_r3");
      @(posedge clk); #1;

      // Reset during SHIFT drops the operation.
      req_a[7:0]   = 8'hCC;
      req_amt[2:0] = 3'd3;
      req_valid    = 4'b0001;
      #1;
      chk("mr_grant", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = 4'b0000;
      chk("mr_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mr_busy",   32'(busy), 32'd0);
      chk("mr_valid",  32'(out_valid), 32'd0);
      chk("mr_sh_a",   32'(sh_a), 32'd0);
      chk("mr_sh_amt", 32'(sh_amt), 32'd0);
      chk("mr_out_y",  32'(out_y), 32'd0);
      chk("mr_out_id", 32'(out_id), 32'd0);
      chk("mr_ready",  32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mr_no_output", 32'(out_valid), 32'd0);
      end

      // All requesters valid continuously.
      exp_y[0] = 8'h80; exp_y[1] = 8'h01; exp_y[2] = 8'h0F; exp_y[3] = 8'hC0;
      req_a   = {8'h81, 8'hF0, 8'h02, 8'h01};
      req_amt = {3'd1, 3'd4, 3'd1, 3'd1};
`ifdef BARREL_ARB_RR_EN
      order = '{0, 1, 2, 3, 0};
`else
      order = '{0, 0, 0, 0, 0};
`endif
      for (int i = 0; i < 5; i++) sb.push_back({2'(order[i]), exp_y[order[i]]});
      req_valid = 4'b1111;
      #1;
      chk("all_first_grant", 32'(req_ready), 32'b0001);
      for (int i = 0; i < 5; i++) begin
         collect("all_op");
         @(posedge clk); #1;
      end
      req_valid = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      chk("end_busy",     32'(busy), 32'd0);
      chk("end_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
